sum_join_fifo: RTL and testbench

//   Synthesizable N-channel join-and-add buffer. Each upstream channel pushes into its own FIFO.

---
 rtl/sum_join_fifo_if.sv | 29 ++
 rtl/sum_join_fifo.sv | 147 ++++++++++++++
 tb/tb_sum_join_fifo.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sum_join_fifo_if.sv
// Handshake bundle for sum_join_fifo: per-channel push side, single pop side and sticky status flags.
interface sum_join_fifo_if #(
   parameter int D_WIDTH   = 6,
   parameter int NUM_CH    = 2,
   parameter int OUT_DEPTH = 4
);
   localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

   logic [NUM_CH*D_WIDTH-1:0] up_data;
   logic [NUM_CH-1:0]         push;
   logic [NUM_CH-1:0]         up_ready;
   logic [D_WIDTH-1:0]        down_data;
   logic                      down_valid;
   logic                      pop;
   logic [CNT_W-1:0]          out_count;
   logic [NUM_CH-1:0]         push_drop_err;
   logic                      pop_empty_err;
   logic                      sat_hit;

   modport master (
      output up_data, push, pop,
      input  up_ready, down_data, down_valid, out_count, push_drop_err, pop_empty_err, sat_hit
   );

   modport slave (
      input  up_data, push, pop,
      output up_ready, down_data, down_valid, out_count, push_drop_err, pop_empty_err, sat_hit
   );
endinterface

// File: rtl/sum_join_fifo.sv
// N-channel join-and-add buffer: one FIFO per input channel, heads are summed into an output FIFO
// whenever every channel has data and the output FIFO has room.
module sum_join_fifo #(
   parameter int D_WIDTH   = 6,
   parameter int NUM_CH    = 2,
   parameter int IN_DEPTH  = 4,
   parameter int OUT_DEPTH = 4,
   parameter int SATURATE  = 0
)(
   input  logic           clk,
   input  logic           rst,
   sum_join_fifo_if.slave bus
);
   localparam int IN_AW  = $clog2(IN_DEPTH);
   localparam int OUT_AW = $clog2(OUT_DEPTH);
   localparam int CNT_W  = OUT_AW + 1;
   localparam int SUM_W  = D_WIDTH + $clog2(NUM_CH);
   localparam logic [IN_AW:0]     IN_FULL  = (IN_AW+1)'(IN_DEPTH);
   localparam logic [CNT_W-1:0]   OUT_FULL = CNT_W'(OUT_DEPTH);
   localparam logic [SUM_W-1:0]   SUM_MAX  = SUM_W'((2**D_WIDTH) - 1);

   logic [NUM_CH-1:0][D_WIDTH-1:0] w_head;
   logic [NUM_CH-1:0]              w_nonempty;
   logic [NUM_CH-1:0]              w_full;
   logic [NUM_CH-1:0]              w_drop;
   logic                           w_join;
   logic [SUM_W-1:0]               w_sum;
   logic                           w_clamp;
   logic [D_WIDTH-1:0]             w_result;
   logic                           w_out_ne;
   logic                           w_pop_ok;

   logic [D_WIDTH-1:0] r_out_mem [OUT_DEPTH];
   logic [OUT_AW-1:0]  r_out_wr;
   logic [OUT_AW-1:0]  r_out_rd;
   logic [CNT_W-1:0]   r_out_cnt;
   logic [D_WIDTH-1:0] r_hold;
   logic [NUM_CH-1:0]  r_drop_err;
   logic               r_pop_err;
   logic               r_sat;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
         logic [D_WIDTH-1:0] r_mem [IN_DEPTH];
         logic [IN_AW-1:0]   r_wr_ptr;
         logic [IN_AW-1:0]   r_rd_ptr;
         logic [IN_AW:0]     r_cnt;
         logic               w_wr;

         // Fullness is taken from the registered count, so a join in the same cycle never frees a slot
         assign w_full[gi]     = (r_cnt == IN_FULL);
         assign w_nonempty[gi] = (r_cnt != '0);
         assign w_wr           = bus.push[gi] & ~w_full[gi];
         assign w_drop[gi]     = bus.push[gi] & w_full[gi];
         assign w_head[gi]     = r_mem[r_rd_ptr];

         always_ff @(posedge clk) begin
            if (w_wr) begin
               r_mem[r_wr_ptr] <= bus.up_data[gi*D_WIDTH +: D_WIDTH];
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               r_wr_ptr <= '0;
               r_rd_ptr <= '0;
               r_cnt    <= '0;
            end else begin
               if (w_wr) begin
                  r_wr_ptr <= r_wr_ptr + 1'b1;
               end
               if (w_join) begin
                  r_rd_ptr <= r_rd_ptr + 1'b1;
               end
               case ({w_wr, w_join})
                  2'b10:   r_cnt <= r_cnt + 1'b1;
                  2'b01:   r_cnt <= r_cnt - 1'b1;
                  default: r_cnt <= r_cnt;
               endcase
            end
         end
      end
   endgenerate

   always_comb begin
      w_sum = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         w_sum = w_sum + SUM_W'(w_head[c]);
      end
   end

   assign w_clamp  = (SATURATE != 0) && (w_sum > SUM_MAX);
   assign w_result = w_clamp ? '1 : w_sum[D_WIDTH-1:0];

   // A pop in the same cycle does not make room for a join
   assign w_out_ne = (r_out_cnt != '0);
   assign w_join   = (&w_nonempty) && (r_out_cnt != OUT_FULL);
   assign w_pop_ok = bus.pop & w_out_ne;

   always_ff @(posedge clk) begin
      if (w_join) begin
         r_out_mem[r_out_wr] <= w_result;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_wr   <= '0;
         r_out_rd   <= '0;
         r_out_cnt  <= '0;
         r_hold     <= '0;
         r_drop_err <= '0;
         r_pop_err  <= 1'b0;
         r_sat      <= 1'b0;
      end else begin
         if (w_join) begin
            r_out_wr <= r_out_wr + 1'b1;
         end
         if (w_pop_ok) begin
            r_out_rd <= r_out_rd + 1'b1;
            r_hold   <= r_out_mem[r_out_rd];
         end
         case ({w_join, w_pop_ok})
            2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
            2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
            default: r_out_cnt <= r_out_cnt;
         endcase
         r_drop_err <= r_drop_err | w_drop;
         if (bus.pop && !w_out_ne) begin
            r_pop_err <= 1'b1;
         end
         if (w_join && w_clamp) begin
            r_sat <= 1'b1;
         end
      end
   end

   // First-word-fall-through head; the last popped value is held while empty
   assign bus.down_data     = w_out_ne ? r_out_mem[r_out_rd] : r_hold;
   assign bus.down_valid    = w_out_ne;
   assign bus.out_count     = r_out_cnt;
   assign bus.up_ready      = ~w_full;
   assign bus.push_drop_err = r_drop_err;
   assign bus.pop_empty_err = r_pop_err;
   assign bus.sat_hit       = r_sat;
endmodule

// File: tb/tb_sum_join_fifo.sv
// Bench for sum_join_fifo: vector table, directed corner sequences and a queue-based random model.
module tb_sum_join_fifo;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   sum_join_fifo_if #(.D_WIDTH(6), .NUM_CH(2), .OUT_DEPTH(4)) ifa ();
   sum_join_fifo_if #(.D_WIDTH(6), .NUM_CH(2), .OUT_DEPTH(4)) ifb ();
   sum_join_fifo_if #(.D_WIDTH(6), .NUM_CH(4), .OUT_DEPTH(4)) ifc ();

   sum_join_fifo #(.D_WIDTH(6), .NUM_CH(2), .IN_DEPTH(4), .OUT_DEPTH(4), .SATURATE(0))
      dut_a (.clk(clk), .rst(rst), .bus(ifa));
   sum_join_fifo #(.D_WIDTH(6), .NUM_CH(2), .IN_DEPTH(4), .OUT_DEPTH(4), .SATURATE(1))
      dut_b (.clk(clk), .rst(rst), .bus(ifb));
   sum_join_fifo #(.D_WIDTH(6), .NUM_CH(4), .IN_DEPTH(4), .OUT_DEPTH(4), .SATURATE(0))
      dut_c (.clk(clk), .rst(rst), .bus(ifc));

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       rst;
      logic [1:0] push;
      logic [5:0] d0;
      logic [5:0] d1;
      logic       pop;
      logic       e_valid;
      logic [5:0] e_data;
      logic [2:0] e_count;
      logic [1:0] e_ready;
      logic [1:0] e_drop;
      logic       e_perr;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic r, input logic [1:0] p, input int d0, input int d1,
                               input logic pp, input logic ev, input int ed, input int ec,
                               input logic [1:0] er, input logic [1:0] edr, input logic epe);
      vec_t v;
      v.rst = r; v.push = p; v.d0 = 6'(d0); v.d1 = 6'(d1); v.pop = pp;
      v.e_valid = ev; v.e_data = 6'(ed); v.e_count = 3'(ec);
      v.e_ready = er; v.e_drop = edr; v.e_perr = epe;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model for dut_a: plain queues and the join/pop rules applied to pre-edge state
   int   mq0[$], mq1[$], moq[$];
   logic [1:0] mdrop;
   logic mperr;

   task automatic model_step(input logic [1:0] p, input int d0, input int d1, input logic pp);
      bit f0 = (mq0.size() == 4);
      bit f1 = (mq1.size() == 4);
      bit j  = (mq0.size() > 0) && (mq1.size() > 0) && (moq.size() < 4);
      int s;
      if (pp) begin
         if (moq.size() > 0) void'(moq.pop_front());
         else mperr = 1'b1;
      end
      if (j) begin
         s = mq0.pop_front() + mq1.pop_front();
         moq.push_back(s % 64);
      end
      if (p[0]) begin
         if (!f0) mq0.push_back(d0);
         else mdrop[0] = 1'b1;
      end
      if (p[1]) begin
         if (!f1) mq1.push_back(d1);
         else mdrop[1] = 1'b1;
      end
   endtask

   initial begin
      int exp_q[$];
      logic [1:0] rp;
      int rd0, rd1, popw, pushw;
      logic rpp;

      rst = 1'b1;
      ifa.push = '0; ifa.up_data = '0; ifa.pop = 1'b0;
      ifb.push = '0; ifb.up_data = '0; ifb.pop = 1'b0;
      ifc.push = '0; ifc.up_data = '0; ifc.pop = 1'b0;

      // rst push d0 d1 pop | valid data count ready drop perr
      tbl.push_back(mk(1, 2'b00,  0,  0, 0, 0,  0, 0, 2'b11, 2'b00, 0));
      tbl.push_back(mk(0, 2'b11,  5,  7, 0, 0,  0, 0, 2'b11, 2'b00, 0));
      tbl.push_back(mk(0, 2'b00,  0,  0, 0, 1, 12, 1, 2'b11, 2'b00, 0));
      tbl.push_back(mk(0, 2'b00,  0,  0, 1, 0,  0, 0, 2'b11, 2'b00, 0));
      tbl.push_back(mk(0, 2'b00,  0,  0, 1, 0,  0, 0, 2'b11, 2'b00, 1));
      tbl.push_back(mk(1, 2'b00,  0,  0, 0, 0,  0, 0, 2'b11, 2'b00, 0));
      tbl.push_back(mk(0, 2'b11, 40, 30, 0, 0,  0, 0, 2'b11, 2'b00, 0));
      tbl.push_back(mk(0, 2'b00,  0,  0, 0, 1,  6, 1, 2'b11, 2'b00, 0));
      tbl.push_back(mk(0, 2'b00,  0,  0, 1, 0,  0, 0, 2'b11, 2'b00, 0));
      tbl.push_back(mk(0, 2'b01,  1,  0, 0, 0,  0, 0, 2'b11, 2'b00, 0));
      tbl.push_back(mk(0, 2'b01,  2,  0, 0, 0,  0, 0, 2'b11, 2'b00, 0));
      tbl.push_back(mk(0, 2'b01,  3,  0, 0, 0,  0, 0, 2'b11, 2'b00, 0));
      tbl.push_back(mk(0, 2'b01,  4,  0, 0, 0,  0, 0, 2'b10, 2'b00, 0));
      tbl.push_back(mk(0, 2'b01,  9,  0, 0, 0,  0, 0, 2'b10, 2'b01, 0));
      tbl.push_back(mk(0, 2'b10,  0, 10, 0, 0,  0, 0, 2'b10, 2'b01, 0));
      tbl.push_back(mk(0, 2'b10,  0, 20, 0, 1, 11, 1, 2'b11, 2'b01, 0));
      tbl.push_back(mk(0, 2'b10,  0, 30, 0, 1, 11, 2, 2'b11, 2'b01, 0));
      tbl.push_back(mk(0, 2'b10,  0, 40, 0, 1, 11, 3, 2'b11, 2'b01, 0));
      tbl.push_back(mk(0, 2'b00,  0,  0, 0, 1, 11, 4, 2'b11, 2'b01, 0));
      tbl.push_back(mk(0, 2'b00,  0,  0, 1, 1, 22, 3, 2'b11, 2'b01, 0));
      tbl.push_back(mk(0, 2'b00,  0,  0, 1, 1, 33, 2, 2'b11, 2'b01, 0));
      tbl.push_back(mk(0, 2'b00,  0,  0, 1, 1, 44, 1, 2'b11, 2'b01, 0));
      tbl.push_back(mk(0, 2'b00,  0,  0, 1, 0,  0, 0, 2'b11, 2'b01, 0));
      tbl.push_back(mk(1, 2'b00,  0,  0, 0, 0,  0, 0, 2'b11, 2'b00, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst;
         ifa.push = tbl[i].push;
         ifa.up_data = {tbl[i].d1, tbl[i].d0};
         ifa.pop = tbl[i].pop;
         tick();
         rst = 1'b0; ifa.push = '0; ifa.pop = 1'b0;
         chk($sformatf("vec%0d valid", i), ifa.down_valid, tbl[i].e_valid);
         if (tbl[i].e_valid) chk($sformatf("vec%0d data", i), ifa.down_data, tbl[i].e_data);
         chk($sformatf("vec%0d count", i), ifa.out_count, tbl[i].e_count);
         chk($sformatf("vec%0d ready", i), ifa.up_ready, tbl[i].e_ready);
         chk($sformatf("vec%0d drop", i), ifa.push_drop_err, tbl[i].e_drop);
         chk($sformatf("vec%0d perr", i), ifa.pop_empty_err, tbl[i].e_perr);
         chk($sformatf("vec%0d sat", i), ifa.sat_hit, 0);
         $display("vec %0d: valid=%0d data=%0d count=%0d", i, ifa.down_valid, ifa.down_data, ifa.out_count);
      end

      // Back-pressure: six pairs with no pops fill the output and leave two per channel
      for (int i = 0; i < 6; i++) begin
         ifa.push = 2'b11;
         ifa.up_data = {6'(2*i + 1), 6'(i + 3)};
         exp_q.push_back((3*i + 4) % 64);
         tick();
      end
      ifa.push = '0;
      repeat (3) tick();
      chk("bp count full", ifa.out_count, 4);
      chk("bp head", ifa.down_data, exp_q[0]);
      chk("bp ready", ifa.up_ready, 2'b11);
      $display("bp: count=%0d head=%0d", ifa.out_count, ifa.down_data);
      ifa.pop = 1'b1;
      tick();
      ifa.pop = 1'b0;
      chk("bp count after pop", ifa.out_count, 3);
      chk("bp head after pop", ifa.down_data, exp_q[1]);
      tick();
      chk("bp refill count", ifa.out_count, 4);
      void'(exp_q.pop_front());
      for (int k = 0; k < 30 && exp_q.size() > 0; k++) begin
         if (ifa.down_valid) begin
            chk($sformatf("bp drain %0d", k), ifa.down_data, exp_q.pop_front());
            ifa.pop = 1'b1;
         end else begin
            ifa.pop = 1'b0;
         end
         tick();
      end
      ifa.pop = 1'b0;
      chk("bp drained all", exp_q.size(), 0);
      chk("bp empty", ifa.down_valid, 0);
      $display("bp drain done: left=%0d", exp_q.size());

      // Pop on empty, then reset with results queued
      ifa.pop = 1'b1;
      tick();
      ifa.pop = 1'b0;
      chk("empty pop perr", ifa.pop_empty_err, 1);
      chk("empty pop count", ifa.out_count, 0);
      for (int i = 0; i < 3; i++) begin
         ifa.push = 2'b11; ifa.up_data = {6'(i), 6'(i + 1)};
         tick();
      end
      ifa.push = '0;
      repeat (2) tick();
      chk("pre-reset count", ifa.out_count, 3);
      rst = 1'b1; ifa.push = 2'b11;
      tick();
      rst = 1'b0; ifa.push = '0;
      chk("mid reset count", ifa.out_count, 0);
      chk("mid reset valid", ifa.down_valid, 0);
      chk("mid reset ready", ifa.up_ready, 2'b11);
      chk("mid reset perr", ifa.pop_empty_err, 0);
      chk("mid reset drop", ifa.push_drop_err, 0);
      tick();
      chk("post reset no join", ifa.down_valid, 0);
      $display("mid reset: count=%0d valid=%0d", ifa.out_count, ifa.down_valid);

      // Saturating instance
      ifb.push = 2'b11; ifb.up_data = {6'd10, 6'd20};
      tick();
      ifb.up_data = {6'd30, 6'd40};
      tick();
      ifb.push = '0;
      chk("sat first data", ifb.down_data, 30);
      chk("sat first flag", ifb.sat_hit, 0);
      tick();
      chk("sat count", ifb.out_count, 2);
      chk("sat flag", ifb.sat_hit, 1);
      ifb.pop = 1'b1;
      tick();
      ifb.pop = 1'b0;
      chk("sat clamped data", ifb.down_data, 63);
      $display("sat: data=%0d sat_hit=%0d", ifb.down_data, ifb.sat_hit);

      // Four-channel instance
      ifc.push = 4'hF; ifc.up_data = {4{6'd15}};
      tick();
      ifc.push = '0;
      tick();
      chk("ch4 valid", ifc.down_valid, 1);
      chk("ch4 data", ifc.down_data, 60);
      chk("ch4 count", ifc.out_count, 1);
      ifc.pop = 1'b1;
      tick();
      ifc.pop = 1'b0;
      chk("ch4 popped", ifc.out_count, 0);
      for (int k = 0; k < 12; k++) begin
         ifc.push = 4'hF;
         for (int c = 0; c < 4; c++) ifc.up_data[c*6 +: 6] = 6'(k + c);
         ifc.pop = (k >= 2);
         tick();
         if (k >= 1) begin
            chk($sformatf("stream %0d valid", k), ifc.down_valid, 1);
            chk($sformatf("stream %0d data", k), ifc.down_data, (4*(k-1) + 6) % 64);
            chk($sformatf("stream %0d count", k), ifc.out_count, 1);
         end
         $display("stream %0d: data=%0d count=%0d", k, ifc.down_data, ifc.out_count);
      end
      ifc.push = '0; ifc.pop = 1'b0;

      // Random traffic on dut_a against the queue model
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mq0.delete(); mq1.delete(); moq.delete();
      mdrop = '0; mperr = 1'b0;
      for (int n = 0; n < 600; n++) begin
         popw  = (n < 200) ? 2 : (n < 400) ? 9 : 5;
         pushw = (n < 200) ? 8 : (n < 400) ? 3 : 7;
         rp[0] = ($urandom_range(0, 9) < pushw);
         rp[1] = ($urandom_range(0, 9) < pushw);
         rd0 = $urandom_range(0, 63);
         rd1 = $urandom_range(0, 63);
         rpp = ($urandom_range(0, 9) < popw);
         ifa.push = rp; ifa.up_data = {6'(rd1), 6'(rd0)}; ifa.pop = rpp;
         model_step(rp, rd0, rd1, rpp);
         tick();
         chk($sformatf("rnd%0d valid", n), ifa.down_valid, moq.size() > 0);
         if (moq.size() > 0) chk($sformatf("rnd%0d data", n), ifa.down_data, moq[0]);
         chk($sformatf("rnd%0d count", n), ifa.out_count, moq.size());
         chk($sformatf("rnd%0d ready", n), ifa.up_ready, {mq1.size() < 4, mq0.size() < 4});
         chk($sformatf("rnd%0d drop", n), ifa.push_drop_err, mdrop);
         chk($sformatf("rnd%0d perr", n), ifa.pop_empty_err, mperr);
         if (n % 50 == 0)
            $display("rnd %0d: count=%0d q0=%0d q1=%0d", n, ifa.out_count, mq0.size(), mq1.size());
      end
      ifa.push = '0; ifa.pop = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
